// File: rtl/mc6809_bus_pkg.sv
// mc6809_bus_pkg: quarter encoding and edge-strobe bundle shared by the bus clock
// generator and the clock-enabled CPU core.
package mc6809_bus_pkg;

   typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quarter_t;

   typedef struct packed {
      logic e_rise;
      logic e_fall;
      logic q_rise;
      logic q_fall;
   } edge_strobe_t;

endpackage

// File: rtl/mc6809_quarter_timer.sv
// mc6809_quarter_timer: per-quarter CLK divider with a speed select latched once
// per bus cycle; flags the enabled edge that closes the current quarter.
module mc6809_quarter_timer #(
   parameter int SLOW_DIV = 4,
   parameter int FAST_DIV = 2,
   parameter int DIV_W    = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_cen,
   input  logic i_fast,
   input  logic i_cycle_end,
   output logic o_quarter_end
);

   localparam logic [DIV_W-1:0] SLOW_MAX = DIV_W'(SLOW_DIV - 1);
   localparam logic [DIV_W-1:0] FAST_MAX = DIV_W'(FAST_DIV - 1);

   // divisor kept as div_sel-1 so DIV_W only has to hold SLOW_DIV-1
   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] r_div_max;
   logic             r_start;

   assign o_quarter_end = i_cen && (r_div_cnt == r_div_max);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_cnt <= '0;
         r_div_max <= SLOW_MAX;
         r_start   <= 1'b1;
      end else if (i_cen) begin
         r_div_cnt <= o_quarter_end ? '0 : r_div_cnt + 1'b1;
         r_start   <= 1'b0;
         if (r_start || i_cycle_end)
            r_div_max <= i_fast ? FAST_MAX : SLOW_MAX;
      end
   end

endmodule

// File: rtl/mc6809_busclk_gen.sv
// mc6809_busclk_gen: quadrature E/Q bus clock generator with runtime speed select,
// MRDY stretching with a bounded limit, and one-CLK edge strobes.
module mc6809_busclk_gen
   import mc6809_bus_pkg::*;
#(
   parameter int SLOW_DIV    = 4,
   parameter int FAST_DIV    = 2,
   parameter int DIV_W       = 4,
   parameter int MAX_STRETCH = 40,
   parameter int STR_W       = 6
) (
   input  logic CLK,
   input  logic RESET,
   input  logic CEN,
   input  logic FAST,
   input  logic MRDY,
   output logic E,
   output logic Q,
   output logic E_RISE,
   output logic E_FALL,
   output logic Q_RISE,
   output logic Q_FALL,
   output logic STRETCHED,
   output logic TIMEOUT
);

   quarter_t         r_quarter, w_quarter_nxt;
   logic [STR_W-1:0] r_stretch_cnt, w_stretch_nxt;
   edge_strobe_t     r_str, w_str;
   logic             r_e, r_q, r_stretched, r_timeout;
   logic             w_e_nxt, w_q_nxt, w_stretched_nxt, w_timeout;
   logic             w_qend, w_q3_end, w_hold, w_cycle_end;

   mc6809_quarter_timer #(
      .SLOW_DIV(SLOW_DIV),
      .FAST_DIV(FAST_DIV),
      .DIV_W   (DIV_W)
   ) u_timer (
      .i_clk        (CLK),
      .i_rst        (RESET),
      .i_cen        (CEN),
      .i_fast       (FAST),
      .i_cycle_end  (w_cycle_end),
      .o_quarter_end(w_qend)
   );

   // a Q3 end with MRDY low holds in Q3 until the stretch budget is spent
   assign w_q3_end    = w_qend && (r_quarter == Q3);
   assign w_hold      = w_q3_end && !MRDY && (r_stretch_cnt < STR_W'(MAX_STRETCH));
   assign w_cycle_end = w_q3_end && !w_hold;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_quarter     <= Q0;
         r_stretch_cnt <= '0;
         r_str         <= '0;
         r_e           <= 1'b0;
         r_q           <= 1'b0;
         r_stretched   <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_quarter     <= w_quarter_nxt;
         r_stretch_cnt <= w_stretch_nxt;
         r_str         <= w_str;
         r_e           <= w_e_nxt;
         r_q           <= w_q_nxt;
         r_stretched   <= w_stretched_nxt;
         r_timeout     <= w_timeout;
      end
   end

   always_comb begin
      w_quarter_nxt = (w_qend && !w_hold) ? quarter_t'(r_quarter + 2'd1) : r_quarter;
      w_stretch_nxt = w_cycle_end ? '0 : w_hold ? r_stretch_cnt + 1'b1 : r_stretch_cnt;
   end

   always_comb begin
      w_str.q_rise    = w_qend && (r_quarter == Q0);
      w_str.e_rise    = w_qend && (r_quarter == Q1);
      w_str.q_fall    = w_qend && (r_quarter == Q2);
      w_str.e_fall    = w_cycle_end;
      w_q_nxt         = (r_q || w_str.q_rise) && !w_str.q_fall;
      w_e_nxt         = (r_e || w_str.e_rise) && !w_str.e_fall;
      w_stretched_nxt = w_hold || (r_stretched && !w_cycle_end);
      w_timeout       = w_cycle_end && !MRDY;
   end

   assign E         = r_e;
   assign Q         = r_q;
   assign E_RISE    = r_str.e_rise;
   assign E_FALL    = r_str.e_fall;
   assign Q_RISE    = r_str.q_rise;
   assign Q_FALL    = r_str.q_fall;
   assign STRETCHED = r_stretched;
   assign TIMEOUT   = r_timeout;

endmodule
